// File: rtl/instr_queue.sv
// instr_queue: circular FIFO between fetch and decode.
// Holds fetched instructions with their PC and RVFI order tag.
// The oldest entry is presented first-word-fall-through on iq_out.
// A redirect (flush) empties the queue in a single cycle.

package instr_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
  } if_id_stage_reg_t;

endpackage

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_inst,
  input  logic [31:0]              enq_pc,
  input  logic [63:0]              enq_order,
  output logic                     enq_ready,
  input  logic                     deq_ready,
  output if_id_stage_reg_t         iq_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
  } entry_t;

  localparam logic [PW-1:0] PtrOne = PW'(1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;

  logic [AW-1:0]   w_headIdx;
  logic [AW-1:0]   w_tailIdx;
  logic            w_empty;
  logic            w_full;
  logic            w_enqFire;
  logic            w_deqFire;
  entry_t          w_headEntry;

  // The extra wrap bit distinguishes full from empty when indices match.
  assign w_headIdx = r_head[AW-1:0];
  assign w_tailIdx = r_tail[AW-1:0];
  assign w_empty   = (r_head == r_tail);
  assign w_full    = (w_headIdx == w_tailIdx) && (r_head[AW] != r_tail[AW]);

  // enq_ready only looks at full, so there is no deq-to-enq combinational path.
  assign w_enqFire = enq_valid && !w_full;
  assign w_deqFire = deq_ready && !w_empty;

  assign enq_ready = !w_full;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_tail - r_head;

  // Head entry is shown even when empty; consumers qualify with valid.
  assign w_headEntry  = r_mem[w_headIdx];
  assign iq_out.valid = !w_empty;
  assign iq_out.inst  = w_headEntry.inst;
  assign iq_out.pc    = w_headEntry.pc;
  assign iq_out.order = w_headEntry.order;

  // Pointer update: flush squashes everything and beats any same-cycle enq/deq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enqFire) begin
        r_tail <= r_tail + PtrOne;
      end
      if (w_deqFire) begin
        r_head <= r_head + PtrOne;
      end
    end
  end

  // Entry storage: cleared on reset, written at the tail index on an accepted enqueue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enqFire && !flush) begin
      r_mem[w_tailIdx] <= '{inst: enq_inst, pc: enq_pc, order: enq_order};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue (DEPTH = 8).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.

module tb_instr_queue;
  import instr_queue_pkg::*;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             enqValid;
  logic [31:0]      enqInst;
  logic [31:0]      enqPc;
  logic [63:0]      enqOrder;
  logic             enqReady;
  logic             deqReady;
  if_id_stage_reg_t iqOut;
  logic             full;
  logic             empty;
  logic [3:0]       count;

  int checkCount = 0;
  int failCount  = 0;

  instr_queue #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enqValid),
    .enq_inst  (enqInst),
    .enq_pc    (enqPc),
    .enq_order (enqOrder),
    .enq_ready (enqReady),
    .deq_ready (deqReady),
    .iq_out    (iqOut),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives all request inputs in one go.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [63:0] ord, input logic deq, input logic fl);
    enqValid = v;
    enqInst  = inst;
    enqPc    = pc;
    enqOrder = ord;
    deqReady = deq;
    flush    = fl;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 64'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] inst3 [3];

  initial begin
    inst3[0] = 32'h00500093;
    inst3[1] = 32'h00A00113;
    inst3[2] = 32'h002081B3;

    rst = 1'b1;
    idle();
    #12;
    // Reset state
    checkOutput("rst_count", 160'(count), 160'd0);
    checkOutput("rst_empty", 160'(empty), 160'd1);
    checkOutput("rst_full", 160'(full), 160'd0);
    checkOutput("rst_enq_ready", 160'(enqReady), 160'd1);
    checkOutput("rst_iq_out", 160'(iqOut), 160'd0);
    @(negedge clk);
    rst = 1'b0;
    stepClock();

    // Three back-to-back enqueues
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, inst3[i], 32'h1eceb000 + 32'(4 * i), 64'(i), 1'b0, 1'b0);
      stepClock();
      if (i == 0) begin
        checkOutput("latency_valid", 160'(iqOut.valid), 160'd1);
        checkOutput("latency_pc", 160'(iqOut.pc), 160'h1eceb000);
      end
    end
    idle();
    checkOutput("t1_count", 160'(count), 160'd3);
    checkOutput("t1_head_pc", 160'(iqOut.pc), 160'h1eceb000);
    checkOutput("t1_head_inst", 160'(iqOut.inst), 160'h00500093);
    checkOutput("t1_head_valid", 160'(iqOut.valid), 160'd1);
    deqReady = 1'b1;
    for (int i = 1; i < 3; i++) begin
      stepClock();
      checkOutput("t1_deq_inst", 160'(iqOut.inst), 160'(inst3[i]));
      checkOutput("t1_deq_order", 160'(iqOut.order), 160'(i));
      checkOutput("t1_deq_count", 160'(count), 160'(3 - i));
    end
    stepClock();
    checkOutput("t1_empty", 160'(empty), 160'd1);
    checkOutput("t1_empty_valid", 160'(iqOut.valid), 160'd0);
    idle();

    // Fill to DEPTH (pointers start at 3, so this also crosses the index wrap)
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'(i), 32'h1eceb000 + 32'(4 * i), 64'(10 + i), 1'b0, 1'b0);
      stepClock();
      if (i == 6) checkOutput("fill7_full", 160'(full), 160'd0);
    end
    checkOutput("fill_full", 160'(full), 160'd1);
    checkOutput("fill_enq_ready", 160'(enqReady), 160'd0);
    checkOutput("fill_count", 160'(count), 160'd8);
    applyStimulus(1'b1, 32'hdead, 32'h1eceb020, 64'd99, 1'b0, 1'b0);
    stepClock();
    checkOutput("ninth_count", 160'(count), 160'd8);
    checkOutput("ninth_head_pc", 160'(iqOut.pc), 160'h1eceb000);
    applyStimulus(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0);
    stepClock();
    checkOutput("deq_from_full_count", 160'(count), 160'd7);
    checkOutput("deq_from_full_ready", 160'(enqReady), 160'd1);
    checkOutput("deq_from_full_pc", 160'(iqOut.pc), 160'h1eceb004);
    applyStimulus(1'b1, 32'h8, 32'h1eceb020, 64'd18, 1'b0, 1'b0);
    stepClock();
    checkOutput("refill_count", 160'(count), 160'd8);
    checkOutput("refill_full", 160'(full), 160'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("drain_pc", 160'(iqOut.pc), 160'(32'h1eceb004 + 32'(4 * k)));
      checkOutput("drain_order", 160'(iqOut.order), 160'(11 + k));
      stepClock();
    end
    checkOutput("drain_empty", 160'(empty), 160'd1);
    idle();

    // Streaming wrap-around: count stays at 1, orders come out 0..19
    applyStimulus(1'b1, 32'h0, 32'h2000, 64'd0, 1'b0, 1'b0);
    stepClock();
    for (int i = 1; i < 20; i++) begin
      applyStimulus(1'b1, 32'(i), 32'h2000 + 32'(4 * i), 64'(i), 1'b1, 1'b0);
      checkOutput("stream_order", 160'(iqOut.order), 160'(i - 1));
      checkOutput("stream_count", 160'(count), 160'd1);
      stepClock();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("stream_last_order", 160'(iqOut.order), 160'd19);
    checkOutput("stream_last_count", 160'(count), 160'd1);
    stepClock();
    checkOutput("stream_empty", 160'(empty), 160'd1);
    idle();

    // Simultaneous enq+deq at count 4
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0, 32'h100 + 32'(4 * i), 64'(40 + i), 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("sim_pre_count", 160'(count), 160'd4);
    applyStimulus(1'b1, 32'h0, 32'h110, 64'd44, 1'b1, 1'b0);
    stepClock();
    checkOutput("sim_count", 160'(count), 160'd4);
    checkOutput("sim_head_pc", 160'(iqOut.pc), 160'h104);
    applyStimulus(1'b0, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("sim_drain_pc", 160'(iqOut.pc), 160'(32'h104 + 32'(4 * k)));
      stepClock();
    end
    checkOutput("sim_drain_empty", 160'(empty), 160'd1);
    idle();

    // Flush at count 5 with enq and deq in the same cycle
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h0, 32'h300 + 32'(4 * i), 64'(50 + i), 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("flush_pre_count", 160'(count), 160'd5);
    applyStimulus(1'b1, 32'hbad, 32'hbad0, 64'd666, 1'b1, 1'b1);
    stepClock();
    idle();
    checkOutput("flush_count", 160'(count), 160'd0);
    checkOutput("flush_empty", 160'(empty), 160'd1);
    checkOutput("flush_valid", 160'(iqOut.valid), 160'd0);
    applyStimulus(1'b1, 32'h77, 32'h200, 64'd77, 1'b0, 1'b0);
    stepClock();
    idle();
    checkOutput("post_flush_count", 160'(count), 160'd1);
    checkOutput("post_flush_pc", 160'(iqOut.pc), 160'h200);
    checkOutput("post_flush_order", 160'(iqOut.order), 160'd77);
    deqReady = 1'b1;
    stepClock();
    idle();
    checkOutput("post_flush_empty", 160'(empty), 160'd1);

    // Asynchronous reset between edges at count 6
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'habc0 + 32'(i), 32'h400 + 32'(4 * i), 64'(60 + i), 1'b0, 1'b0);
      stepClock();
    end
    idle();
    checkOutput("arst_pre_count", 160'(count), 160'd6);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_iq_out", 160'(iqOut), 160'd0);
    checkOutput("arst_count", 160'(count), 160'd0);
    checkOutput("arst_enq_ready", 160'(enqReady), 160'd1);
    @(negedge clk);
    rst = 1'b0;
    stepClock();
    applyStimulus(1'b1, 32'h55, 32'h500, 64'd5, 1'b0, 1'b0);
    stepClock();
    idle();
    checkOutput("arst_first_enq_pc", 160'(iqOut.pc), 160'h500);
    checkOutput("arst_first_enq_count", 160'(count), 160'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
